// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle for one port of the SRAM arbiter.
// master = requester (DSP core or Wishbone debug path), slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for a 1R1W SRAM macro with a fixed 2-cycle read return.
// Optional macro SRAM_ARB_BYPASS_EN: same-address read/write collisions forward the write data.
module sram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    sram_port_arbiter_if.slave   m0,
    sram_port_arbiter_if.slave   m1,
    output logic                 R0_clk,
    output logic                 R0_en,
    output logic [AW-1:0]        R0_addr,
    input  logic [DW-1:0]        R0_data,
    output logic                 W0_clk,
    output logic                 W0_en,
    output logic [AW-1:0]        W0_addr,
    output logic [DW-1:0]        W0_data
);
    logic [1:0]    req_valid;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];

    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s1_id_q,  s1_id_d;
    logic [1:0]    rsp_vld_q, rsp_vld_d;
    logic [DW-1:0] rsp_data_q [2];
    logic [DW-1:0] rsp_data_d [2];
`ifdef SRAM_ARB_BYPASS_EN
    logic          s1_byp_q,   s1_byp_d;
    logic [DW-1:0] s1_bdata_q, s1_bdata_d;
`endif

    logic [1:0]    rd_cand, wr_cand, ready;
    logic          rd_any, wr_any, rd_id, wr_id, rd_gnt, collide;
    logic [DW-1:0] rdata;

    assign R0_clk = wb_clk_i;
    assign W0_clk = wb_clk_i;

    assign req_valid    = {m1.req_valid, m0.req_valid};
    assign req_we       = {m1.req_we,    m0.req_we};
    assign req_addr[0]  = m0.req_addr;
    assign req_addr[1]  = m1.req_addr;
    assign req_wdata[0] = m0.req_wdata;
    assign req_wdata[1] = m1.req_wdata;

    assign m0.req_ready = ready[0];
    assign m1.req_ready = ready[1];
    assign m0.rsp_valid = rsp_vld_q[0];
    assign m1.rsp_valid = rsp_vld_q[1];
    assign m0.rsp_data  = rsp_data_q[0];
    assign m1.rsp_data  = rsp_data_q[1];

    always_comb begin
        // Grants are suppressed while reset is held so every output reads zero.
        rd_cand = wb_rst_i ? 2'b00 : (req_valid & ~req_we);
        wr_cand = wb_rst_i ? 2'b00 : (req_valid &  req_we);
        rd_any  = |rd_cand;
        wr_any  = |wr_cand;
        rd_id   = (&rd_cand) ? rd_ptr_q : rd_cand[1];
        wr_id   = (&wr_cand) ? wr_ptr_q : wr_cand[1];
        collide = rd_any && wr_any && (req_addr[rd_id] == req_addr[wr_id]);

`ifdef SRAM_ARB_BYPASS_EN
        rd_gnt     = rd_any;
        s1_byp_d   = collide;
        s1_bdata_d = collide ? req_wdata[wr_id] : '0;
`else
        // Read yields to the write; next cycle it sees the committed data.
        rd_gnt     = rd_any && !collide;
`endif

        ready[0] = (rd_gnt && !rd_id) || (wr_any && !wr_id);
        ready[1] = (rd_gnt &&  rd_id) || (wr_any &&  wr_id);

        rd_ptr_d = rd_gnt ? ~rd_id : rd_ptr_q;
        wr_ptr_d = wr_any ? ~wr_id : wr_ptr_q;

        R0_en   = rd_gnt;
        R0_addr = rd_gnt ? req_addr[rd_id] : '0;
        W0_en   = wr_any;
        W0_addr = wr_any ? req_addr[wr_id]  : '0;
        W0_data = wr_any ? req_wdata[wr_id] : '0;

        s1_vld_d = rd_gnt;
        s1_id_d  = rd_id;

        rdata = R0_data;
`ifdef SRAM_ARB_BYPASS_EN
        if (s1_byp_q) rdata = s1_bdata_q;
`endif

        rsp_vld_d[0]  = s1_vld_q && !s1_id_q;
        rsp_vld_d[1]  = s1_vld_q &&  s1_id_q;
        rsp_data_d[0] = rsp_vld_d[0] ? rdata : rsp_data_q[0];
        rsp_data_d[1] = rsp_vld_d[1] ? rdata : rsp_data_q[1];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_id_q       <= 1'b0;
            rsp_vld_q     <= 2'b00;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
`ifdef SRAM_ARB_BYPASS_EN
            s1_byp_q      <= 1'b0;
            s1_bdata_q    <= '0;
`endif
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            s1_vld_q      <= s1_vld_d;
            s1_id_q       <= s1_id_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_data_q[0] <= rsp_data_d[0];
            rsp_data_q[1] <= rsp_data_d[1];
`ifdef SRAM_ARB_BYPASS_EN
            s1_byp_q      <= s1_byp_d;
            s1_bdata_q    <= s1_bdata_d;
`endif
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter with a behavioural SRAM and a
// grant/response reference model built from the arbitration rules.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v   [2];
    logic        we  [2];
    logic [7:0]  ad  [2];
    logic [31:0] wd  [2];

    logic        R0_clk, R0_en, W0_clk, W0_en;
    logic [7:0]  R0_addr, W0_addr;
    logic [31:0] W0_data;
    logic [31:0] r0_data = '0;
    logic [31:0] sram [256] = '{default: 32'h0};

    sram_port_arbiter_if #(.AW(8), .DW(32)) m0_if ();
    sram_port_arbiter_if #(.AW(8), .DW(32)) m1_if ();

    assign m0_if.req_valid = v[0];
    assign m0_if.req_we    = we[0];
    assign m0_if.req_addr  = ad[0];
    assign m0_if.req_wdata = wd[0];
    assign m1_if.req_valid = v[1];
    assign m1_if.req_we    = we[1];
    assign m1_if.req_addr  = ad[1];
    assign m1_if.req_wdata = wd[1];

    sram_port_arbiter #(.AW(8), .DW(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .R0_clk   (R0_clk),
        .R0_en    (R0_en),
        .R0_addr  (R0_addr),
        .R0_data  (r0_data),
        .W0_clk   (W0_clk),
        .W0_en    (W0_en),
        .W0_addr  (W0_addr),
        .W0_data  (W0_data)
    );

    // Behavioural macro: read-before-write on the same edge, data valid the next cycle.
    always @(posedge clk) begin
        if (R0_en) r0_data <= sram[R0_addr];
        if (W0_en) sram[W0_addr] <= W0_data;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend [$];
    int          rsp_order [$];
    logic [31:0] ref_mem [256];
    int          m_rd_ptr, m_wr_ptr;
    logic        obs_ready [2];
    logic        obs_rv    [2];
    logic [31:0] obs_rd    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        v[0] = 1'b0; v[1] = 1'b0;
        we[0] = 1'b0; we[1] = 1'b0;
    endtask

    task automatic req(input int x, input logic w, input logic [7:0] a, input logic [31:0] d);
        v[x] = 1'b1; we[x] = w; ad[x] = a; wd[x] = d;
    endtask

    // One clock cycle: predict who wins from the rules, compare, then advance the model.
    task automatic do_cycle();
        int          rid, wid;
        logic        g_rd, g_wr, byp;
        logic        rd_c [2];
        logic        wr_c [2];
        logic        e_rdy, e_rv;
        int          rsp_id;
        logic [31:0] rsp_dat;

        @(negedge clk);
        g_rd = 1'b0; g_wr = 1'b0; byp = 1'b0; rid = 0; wid = 0;
        if (!rst) begin
            for (int x = 0; x < 2; x++) begin
                rd_c[x] = v[x] && !we[x];
                wr_c[x] = v[x] && we[x];
            end
            g_rd = rd_c[0] || rd_c[1];
            g_wr = wr_c[0] || wr_c[1];
            rid  = (rd_c[0] && rd_c[1]) ? m_rd_ptr : (rd_c[0] ? 0 : 1);
            wid  = (wr_c[0] && wr_c[1]) ? m_wr_ptr : (wr_c[0] ? 0 : 1);
            if (g_rd && g_wr && ad[rid] == ad[wid]) begin
`ifdef SRAM_ARB_BYPASS_EN
                byp = 1'b1;
`else
                g_rd = 1'b0;
`endif
            end
        end

        rsp_id = -1; rsp_dat = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            rsp_id  = pend[0].id;
            rsp_dat = pend[0].data;
            void'(pend.pop_front());
        end

        obs_ready[0] = m0_if.req_ready; obs_ready[1] = m1_if.req_ready;
        obs_rv[0]    = m0_if.rsp_valid; obs_rv[1]    = m1_if.rsp_valid;
        obs_rd[0]    = m0_if.rsp_data;  obs_rd[1]    = m1_if.rsp_data;

        for (int x = 0; x < 2; x++) begin
            e_rdy = (g_rd && rid == x) || (g_wr && wid == x);
            e_rv  = (rsp_id == x);
            check($sformatf("ready%0d", x), obs_ready[x], e_rdy);
            check($sformatf("rsp_valid%0d", x), obs_rv[x], e_rv);
            if (e_rv) check($sformatf("rsp_data%0d", x), obs_rd[x], rsp_dat);
            if (obs_rv[x]) rsp_order.push_back(x);
        end
        check("r0_en",   R0_en,   g_rd);
        check("r0_addr", R0_addr, g_rd ? ad[rid] : 8'h00);
        check("w0_en",   W0_en,   g_wr);
        check("w0_addr", W0_addr, g_wr ? ad[wid] : 8'h00);
        check("w0_data", W0_data, g_wr ? wd[wid] : 32'h0);

        if (g_rd) begin
            pend.push_back('{due: cyc + 2, id: rid, data: byp ? wd[wid] : ref_mem[ad[rid]]});
            m_rd_ptr = 1 - rid;
        end
        if (g_wr) begin
            ref_mem[ad[wid]] = wd[wid];
            m_wr_ptr = 1 - wid;
        end
        if (rst) begin
            pend.delete();
            m_rd_ptr = 0;
            m_wr_ptr = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int m0_gnt_at;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        m_rd_ptr = 0; m_wr_ptr = 0;
        rst = 1'b1;
        ad[0] = 8'h00; ad[1] = 8'h00; wd[0] = 32'h0; wd[1] = 32'h0;
        idle();

        // Reset
        do_cycle();
        do_cycle();
        check("reset_rsp_valid0", m0_if.rsp_valid, 1'b0);
        check("reset_rsp_data1",  m1_if.rsp_data,  32'h0);
        rst = 1'b0;

        // Write then read back with 2-cycle latency
        req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        do_cycle();
        idle(); req(0, 1'b0, 8'h10, 32'h0);
        do_cycle();
        check("rd10_ready", obs_ready[0], 1'b1);
        idle();
        do_cycle();
        do_cycle();
        check("rd10_rsp_valid0", obs_rv[0], 1'b1);
        check("rd10_rsp_data0",  obs_rd[0], 32'hDEADBEEF);
        check("rd10_rsp_valid1", obs_rv[1], 1'b0);

        // Point the read pointer at m0, then contend for 4 cycles
        req(1, 1'b0, 8'h10, 32'h0);
        do_cycle();
        idle();
        do_cycle();
        do_cycle();
        rsp_order.delete();
        for (int i = 0; i < 4; i++) begin
            req(0, 1'b0, 8'h01, 32'h0);
            req(1, 1'b0, 8'h02, 32'h0);
            do_cycle();
            check("alt_ready0", obs_ready[0], (i % 2) == 0);
            check("alt_ready1", obs_ready[1], (i % 2) == 1);
        end
        idle();
        do_cycle();
        do_cycle();
        check("alt_rsp_count", rsp_order.size(), 4);
        if (rsp_order.size() == 4) begin
            for (int i = 0; i < 4; i++) check("alt_rsp_order", rsp_order[i], i % 2);
        end

        // Independent read and write in the same cycle
        req(0, 1'b1, 8'h20, 32'h11111111);
        do_cycle();
        idle(); req(1, 1'b1, 8'h40, 32'hAAAAAAAA);
        do_cycle();
        idle();
        req(0, 1'b0, 8'h20, 32'h0);
        req(1, 1'b1, 8'h30, 32'h22222222);
        do_cycle();
        check("dual_ready0", obs_ready[0], 1'b1);
        check("dual_ready1", obs_ready[1], 1'b1);
        idle();
        do_cycle();
        do_cycle();
        check("dual_rsp_data0", obs_rd[0], 32'h11111111);

        // Same-address collision
        req(0, 1'b0, 8'h40, 32'h0);
        req(1, 1'b1, 8'h40, 32'h55555555);
        do_cycle();
        check("coll_w_ready1", obs_ready[1], 1'b1);
`ifdef SRAM_ARB_BYPASS_EN
        check("coll_r_ready0", obs_ready[0], 1'b1);
        idle();
        do_cycle();
        do_cycle();
`else
        check("coll_r_ready0", obs_ready[0], 1'b0);
        idle(); req(0, 1'b0, 8'h40, 32'h0);
        do_cycle();
        check("coll_retry_ready0", obs_ready[0], 1'b1);
        idle();
        do_cycle();
        do_cycle();
`endif
        check("coll_rsp_valid0", obs_rv[0], 1'b1);
        check("coll_rsp_data0",  obs_rd[0], 32'h55555555);

        // Reset the cycle after an m1 read grant, with requests still asserted
        idle(); req(1, 1'b0, 8'h30, 32'h0);
        do_cycle();
        check("pre_rst_ready1", obs_ready[1], 1'b1);
        rst = 1'b1;
        req(0, 1'b0, 8'h05, 32'h0);
        req(1, 1'b1, 8'h06, 32'h12345678);
        do_cycle();
        do_cycle();
        check("rst_rsp_valid1", obs_rv[1], 1'b0);
        check("rst_rsp_data0",  obs_rd[0], 32'h0);
        check("rst_rsp_data1",  obs_rd[1], 32'h0);
        check("rst_r0_addr",    R0_addr,   8'h00);
        rst = 1'b0;
        idle();
        req(0, 1'b0, 8'h10, 32'h0);
        req(1, 1'b0, 8'h20, 32'h0);
        do_cycle();
        check("post_rst_rsp_valid1", obs_rv[1], 1'b0);
        check("post_rst_ready0", obs_ready[0], 1'b1);
        check("post_rst_ready1", obs_ready[1], 1'b0);
        idle();
        do_cycle();
        do_cycle();
        do_cycle();

        // Continuous m1 writes with one m0 write
        m0_gnt_at = 99;
        for (int k = 0; k < 4; k++) begin
            idle();
            req(1, 1'b1, 8'h50, 32'hB0000000 + k);
            if (m0_gnt_at == 99) req(0, 1'b1, 8'h60, 32'hCAFEF00D);
            do_cycle();
            if (m0_gnt_at == 99 && obs_ready[0]) m0_gnt_at = k;
        end
        idle();
        do_cycle();
        check("m0_wr_within_2", m0_gnt_at <= 1, 1'b1);
        check("mem_60", sram[8'h60], 32'hCAFEF00D);
        check("mem_50", sram[8'h50], ref_mem[8'h50]);

        // Randomized traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            for (int x = 0; x < 2; x++) begin
                v[x]  = ($urandom_range(0, 99) < 70);
                we[x] = $urandom_range(0, 1) == 1;
                ad[x] = 8'($urandom_range(0, 7));
                wd[x] = $urandom;
            end
            do_cycle();
        end
        idle();
        do_cycle();
        do_cycle();
        do_cycle();
        check("drain_pending", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
